test_pattern_gen: RTL and testbench

Synthetic source for the imager datastream: emits framed `dvo`/`dtypeo`/`datao`/`meta_datao` words in the same format the processing chain (filters, unsharp mask, colour blocks) consumes. It sits at the head of the pipeline, muxed in place of the sensor receiver, and gives those blocks deterministic, cycle-exact stimulus in silicon and in simulation.

---
 rtl/test_pattern_gen_pkg.sv | 42 ++++
 rtl/lfsr16.sv | 40 ++++
 rtl/test_pattern_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_test_pattern_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/test_pattern_gen_pkg.sv
// Shared definitions for the test pattern generator.
// Holds the datastream word-type codes, the pattern mode codes, the FSM state
// encoding and the LFSR seed and step function used by lfsr16.
package test_pattern_gen_pkg;

  // Datastream word types; DTYPE_IDLE is what dtypeo shows when dvo is low.
  localparam int DTYPE_WIDTH = 3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_IDLE        = 3'd0;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 3'd1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 3'd2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 3'd3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 3'd4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 3'd5;

  // Pattern select codes; codes 5..7 fall back to the constant pattern.
  localparam logic [2:0] TP_MODE_CONST   = 3'd0;
  localparam logic [2:0] TP_MODE_HRAMP   = 3'd1;
  localparam logic [2:0] TP_MODE_VRAMP   = 3'd2;
  localparam logic [2:0] TP_MODE_CHECKER = 3'd3;
  localparam logic [2:0] TP_MODE_LFSR    = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FSTART = 3'd1,
    ST_RSTART = 3'd2,
    ST_PIX    = 3'd3,
    ST_REND   = 3'd4,
    ST_HBLANK = 3'd5,
    ST_FEND   = 3'd6,
    ST_VBLANK = 3'd7
  } tp_state_e;

  // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11 (right shift).
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used for the pseudo-random test pattern.
// Ports: clk, reset (sync, active-high), seed_load (reload seed, wins over
// advance), advance (step once), q (current register value).
module lfsr16
  import test_pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic        advance,
  output logic [15:0] q
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  // Next-value selection: reload, step, or hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      lfsr_d = lfsr16_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/test_pattern_gen.sv
// Synthetic framed datastream source for the imager pipeline.
// Emits FRAME_START, (ROW_START, pixels, ROW_END, hblank idle) per row,
// FRAME_END and vblank idle. All outputs are registered.
// Ports: clk, reset (sync, active-high), enable, continuous, start, mode,
// const_value, num_cols, num_rows, hblank, vblank in; dvo, dtypeo, datao,
// meta_datao (frame counter), busy out.
// Build option: define TEST_PATTERN_LFSR_EN to give mode 4 an LFSR pattern;
// without it mode 4 outputs const_value.
module test_pattern_gen
  import test_pattern_gen_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int DIM_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   continuous,
  input  logic                   start,
  input  logic [2:0]             mode,
  input  logic [PIXEL_WIDTH-1:0] const_value,
  input  logic [DIM_WIDTH-1:0]   num_cols,
  input  logic [DIM_WIDTH-1:0]   num_rows,
  input  logic [DIM_WIDTH-1:0]   hblank,
  input  logic [DIM_WIDTH-1:0]   vblank,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0] datao,
  output logic [15:0]            meta_datao,
  output logic                   busy
);

  localparam logic [DIM_WIDTH-1:0]   ZERO   = {DIM_WIDTH{1'b0}};
  localparam logic [DIM_WIDTH-1:0]   ONE    = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PIXEL_WIDTH-1:0] P_ONES = {PIXEL_WIDTH{1'b1}};
  localparam logic [PIXEL_WIDTH-1:0] P_ZERO = {PIXEL_WIDTH{1'b0}};

  tp_state_e state_d, state_q;
  logic [DIM_WIDTH-1:0]   cols_d, cols_q, rows_d, rows_q;
  logic [DIM_WIDTH-1:0]   hblank_d, hblank_q, vblank_d, vblank_q;
  logic [DIM_WIDTH-1:0]   col_d, col_q, row_d, row_q, blank_d, blank_q;
  logic [2:0]             mode_d, mode_q;
  logic [PIXEL_WIDTH-1:0] const_d, const_q;
  logic [15:0]            frame_cnt_d, frame_cnt_q;
  logic                   dvo_d, dvo_q, busy_d, busy_q;
  logic [DTYPE_WIDTH-1:0] dtype_d, dtype_q;
  logic [PIXEL_WIDTH-1:0] data_d, data_q;
  logic [15:0]            meta_d, meta_q;
  logic [PIXEL_WIDTH-1:0] pix_s;
  logic                   last_row_s;
  tp_state_e              after_vblank_s;

`ifdef TEST_PATTERN_LFSR_EN
  logic [15:0] lfsr_s;

  // Seeded while the FRAME_START word is produced so each frame repeats.
  lfsr16 u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .seed_load (state_q == ST_FSTART),
    .advance   (state_q == ST_PIX),
    .q         (lfsr_s)
  );
`endif

  assign last_row_s     = (row_q == rows_q - ONE);
  assign after_vblank_s = (enable && continuous) ? ST_FSTART : ST_IDLE;

  // Pixel value for the current (row, col) from the latched pattern mode.
  always_comb begin
    pix_s = const_q;
    case (mode_q)
      TP_MODE_CONST:   pix_s = const_q;
      TP_MODE_HRAMP:   pix_s = PIXEL_WIDTH'(col_q);
      TP_MODE_VRAMP:   pix_s = PIXEL_WIDTH'(row_q);
      TP_MODE_CHECKER: begin
        if ((col_q[3] ^ row_q[3]) == 1'b1) begin
          pix_s = P_ONES;
        end else begin
          pix_s = P_ZERO;
        end
      end
`ifdef TEST_PATTERN_LFSR_EN
      TP_MODE_LFSR:    pix_s = PIXEL_WIDTH'(lfsr_s);
`else
      TP_MODE_LFSR:    pix_s = const_q;
`endif
      default:         pix_s = const_q;
    endcase
  end

  // Frame sequencing: next state, counters and latched configuration.
  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    rows_d      = rows_q;
    hblank_d    = hblank_q;
    vblank_d    = vblank_q;
    mode_d      = mode_q;
    const_d     = const_q;
    col_d       = col_q;
    row_d       = row_q;
    blank_d     = blank_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && (start || continuous)) begin
          state_d = ST_FSTART;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FSTART: begin
        // Zero dimensions would never terminate the counters; treat as 1.
        cols_d   = (num_cols == ZERO) ? ONE : num_cols;
        rows_d   = (num_rows == ZERO) ? ONE : num_rows;
        hblank_d = hblank;
        vblank_d = vblank;
        mode_d   = mode;
        const_d  = const_value;
        row_d    = ZERO;
        state_d  = ST_RSTART;
      end
      ST_RSTART: begin
        col_d   = ZERO;
        state_d = ST_PIX;
      end
      ST_PIX: begin
        if (col_q == cols_q - ONE) begin
          state_d = ST_REND;
        end else begin
          col_d   = col_q + ONE;
          state_d = ST_PIX;
        end
      end
      ST_REND, ST_HBLANK: begin
        // REND with no hblank, or the final hblank cycle, closes the row.
        if ((state_q == ST_REND && hblank_q == ZERO) ||
            (state_q == ST_HBLANK && blank_q == hblank_q - ONE)) begin
          if (last_row_s) begin
            state_d = ST_FEND;
          end else begin
            row_d   = row_q + ONE;
            state_d = ST_RSTART;
          end
        end else if (state_q == ST_REND) begin
          blank_d = ZERO;
          state_d = ST_HBLANK;
        end else begin
          blank_d = blank_q + ONE;
          state_d = ST_HBLANK;
        end
      end
      ST_FEND: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (vblank_q == ZERO) begin
          state_d = after_vblank_s;
        end else begin
          blank_d = ZERO;
          state_d = ST_VBLANK;
        end
      end
      ST_VBLANK: begin
        if (blank_q == vblank_q - ONE) begin
          state_d = after_vblank_s;
        end else begin
          blank_d = blank_q + ONE;
          state_d = ST_VBLANK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output word for the current state, registered on the next edge.
  always_comb begin
    dvo_d   = 1'b0;
    dtype_d = DTYPE_IDLE;
    data_d  = P_ZERO;
    meta_d  = frame_cnt_q;
    busy_d  = (state_q != ST_IDLE);
    case (state_q)
      ST_FSTART: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_FRAME_START;
      end
      ST_RSTART: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_ROW_START;
      end
      ST_PIX: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_PIXEL;
        data_d  = pix_s;
      end
      ST_REND: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_ROW_END;
      end
      ST_FEND: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_FRAME_END;
      end
      default: begin
        dvo_d   = 1'b0;
        dtype_d = DTYPE_IDLE;
      end
    endcase
  end

  // State, configuration, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cols_q      <= ONE;
      rows_q      <= ONE;
      hblank_q    <= ZERO;
      vblank_q    <= ZERO;
      mode_q      <= TP_MODE_CONST;
      const_q     <= P_ZERO;
      col_q       <= ZERO;
      row_q       <= ZERO;
      blank_q     <= ZERO;
      frame_cnt_q <= 16'd0;
      dvo_q       <= 1'b0;
      dtype_q     <= DTYPE_IDLE;
      data_q      <= P_ZERO;
      meta_q      <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      mode_q      <= mode_d;
      const_q     <= const_d;
      col_q       <= col_d;
      row_q       <= row_d;
      blank_q     <= blank_d;
      frame_cnt_q <= frame_cnt_d;
      dvo_q       <= dvo_d;
      dtype_q     <= dtype_d;
      data_q      <= data_d;
      meta_q      <= meta_d;
      busy_q      <= busy_d;
    end
  end

  assign dvo        = dvo_q;
  assign dtypeo     = dtype_q;
  assign datao      = data_q;
  assign meta_datao = meta_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen: directed scenarios plus random
// single frames, each compared cycle by cycle against an expected word list
// built from the frame-format rules.
module tb_test_pattern_gen;
  import test_pattern_gen_pkg::*;

  typedef logic [28:0] word_t; // {dvo, dtype, data, meta, busy}

  logic        clk = 1'b0;
  logic        reset, enable, continuous, start;
  logic [2:0]  mode;
  logic [7:0]  const_value;
  logic [11:0] num_cols, num_rows, hblank, vblank;
  logic        dvo, busy;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [7:0]  datao;
  logic [15:0] meta_datao;

  word_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    fc = 0;
  int    drop_idx = -1;
  bit    drop_en = 1'b0, drop_cont = 1'b0, rand_start = 1'b0, scramble = 1'b0;

  test_pattern_gen #(.PIXEL_WIDTH(8), .DIM_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .enable(enable), .continuous(continuous),
    .start(start), .mode(mode), .const_value(const_value),
    .num_cols(num_cols), .num_rows(num_rows), .hblank(hblank), .vblank(vblank),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .meta_datao(meta_datao), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic word_t mk(input bit v, input logic [DTYPE_WIDTH-1:0] t,
                               input logic [7:0] d, input int m, input bit b);
    logic [15:0] m16;
    m16 = 16'(m);
    return {v, t, d, m16, b};
  endfunction

  // Expected pixel from the pattern definitions.
  function automatic logic [7:0] pix_ref(input int md, input logic [7:0] cv,
                                         input int r, input int c, input int lf);
    case (md)
      1: return 8'(c % 256);
      2: return 8'(r % 256);
      3: return ((((c / 8) + (r / 8)) % 2) == 1) ? 8'hFF : 8'h00;
`ifdef TEST_PATTERN_LFSR_EN
      4: return 8'(lf);
`endif
      default: return cv;
    endcase
  endfunction

  // Drive the configuration inputs and append the expected frame to exp_q.
  task automatic set_cfg(input int cols, input int rows, input int hb, input int vb,
                         input int md, input logic [7:0] cv);
    int c, r, lf, fb;
    num_cols = 12'(cols); num_rows = 12'(rows); hblank = 12'(hb); vblank = 12'(vb);
    mode = 3'(md); const_value = cv;
    c  = (cols == 0) ? 1 : cols;
    r  = (rows == 0) ? 1 : rows;
    lf = 'hACE1;
    exp_q.push_back(mk(1'b1, DTYPE_FRAME_START, 8'h00, fc, 1'b1));
    for (int y = 0; y < r; y++) begin
      exp_q.push_back(mk(1'b1, DTYPE_ROW_START, 8'h00, fc, 1'b1));
      for (int x = 0; x < c; x++) begin
        exp_q.push_back(mk(1'b1, DTYPE_PIXEL, pix_ref(md, cv, y, x, lf), fc, 1'b1));
        fb = (lf ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1;
        lf = (lf >> 1) | (fb << 15);
      end
      exp_q.push_back(mk(1'b1, DTYPE_ROW_END, 8'h00, fc, 1'b1));
      for (int k = 0; k < hb; k++) exp_q.push_back(mk(1'b0, DTYPE_IDLE, 8'h00, fc, 1'b1));
    end
    exp_q.push_back(mk(1'b1, DTYPE_FRAME_END, 8'h00, fc, 1'b1));
    fc++;
    for (int k = 0; k < vb; k++) exp_q.push_back(mk(1'b0, DTYPE_IDLE, 8'h00, fc, 1'b1));
  endtask

  task automatic compare(input string tag, input int i, input word_t expv);
    word_t obs;
    obs = {dvo, dtypeo, datao, meta_datao, busy};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, expv);
    end
  endtask

  // Compare the first n expected words, one per cycle, then clear the list.
  task automatic check_stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare(tag, i, exp_q[i]);
      if (i == drop_idx) begin
        if (drop_en) enable = 1'b0;
        if (drop_cont) continuous = 1'b0;
      end
      if (scramble && i == 1) begin
        num_cols = 12'($urandom_range(0, 15)); num_rows = 12'($urandom_range(0, 7));
        hblank = 12'($urandom_range(0, 5)); vblank = 12'($urandom_range(0, 5));
        mode = 3'($urandom_range(0, 7)); const_value = 8'($urandom);
      end
      if (rand_start) start = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    exp_q.delete();
    drop_idx = -1; drop_en = 1'b0; drop_cont = 1'b0;
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare(tag, i, mk(1'b0, DTYPE_IDLE, 8'h00, fc, 1'b0));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fc = 0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; continuous = 1'b0; start = 1'b0;
    mode = 3'd0; const_value = 8'h00;
    num_cols = 12'd0; num_rows = 12'd0; hblank = 12'd0; vblank = 12'd0;
    repeat (3) @(negedge clk);
    compare("reset", 0, mk(1'b0, DTYPE_IDLE, 8'h00, 0, 1'b0));
    reset = 1'b0;

    // start without enable is ignored
    start = 1'b1;
    expect_idle("no_enable", 3);
    start = 1'b0;
    enable = 1'b1;

    // basic ramp frame: 4x2, hblank 2, vblank 3 -> 21 cycles
    set_cfg(4, 2, 2, 3, 1, 8'h00);
    pulse_start();
    check_stream("ramp_frame", exp_q.size());
    expect_idle("after_ramp", 2);

    // continuous checkerboard, three back-to-back frames
    do_reset();
    set_cfg(16, 16, 0, 0, 3, 8'h00);
    set_cfg(16, 16, 0, 0, 3, 8'h00);
    set_cfg(16, 16, 0, 0, 3, 8'h00);
    drop_idx = 2 * 290; drop_cont = 1'b1;
    continuous = 1'b1;
    @(negedge clk);
    check_stream("cont_checker", exp_q.size());
    expect_idle("after_cont", 2);

    // enable dropped at row 1 of a continuous run: frame completes, then idle
    set_cfg(3, 3, 1, 2, 2, 8'h00);
    drop_idx = 7; drop_en = 1'b1;
    continuous = 1'b1;
    @(negedge clk);
    check_stream("enable_drop", exp_q.size());
    expect_idle("idle_after_drop", 3);
    continuous = 1'b0;
    start = 1'b1;
    expect_idle("start_disabled", 3);
    start = 1'b0;
    enable = 1'b1;
    expect_idle("reenabled", 1);
    set_cfg(2, 1, 0, 1, 0, 8'h5A);
    pulse_start();
    check_stream("restart_frame", exp_q.size());

    // reset in the middle of the pixel run
    set_cfg(6, 2, 1, 1, 1, 8'h00);
    pulse_start();
    check_stream("abort_prefix", 4);
    reset = 1'b1;
    @(negedge clk);
    fc = 0;
    compare("abort_reset", 0, mk(1'b0, DTYPE_IDLE, 8'h00, 0, 1'b0));
    reset = 1'b0;
    set_cfg(2, 2, 0, 0, 2, 8'h00);
    pulse_start();
    check_stream("post_abort", exp_q.size());

    // zero dimensions are treated as 1
    set_cfg(0, 0, 0, 0, 1, 8'h00);
    pulse_start();
    check_stream("zero_dims", exp_q.size());
    expect_idle("after_zero", 1);

    // mode 4 twice: LFSR restarts each frame (or constant without LFSR)
    for (int f = 0; f < 2; f++) begin
      set_cfg(5, 2, 1, 1, 4, 8'h3C);
      pulse_start();
      check_stream("lfsr_frame", exp_q.size());
    end

    // random single frames with mid-frame input changes and stray starts
    for (int t = 0; t < 10; t++) begin
      set_cfg($urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 7), 8'($urandom));
      pulse_start();
      scramble = 1'b1; rand_start = 1'b1;
      check_stream("random_frame", exp_q.size());
      scramble = 1'b0; rand_start = 1'b0;
      expect_idle("random_idle", 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
